// File: rtl/fifo_reader.sv
// Read-side drain controller: issues FIFO read strobes and returns the words on a
// registered valid/ready stream through an output register plus one skid register.
module fifo_reader #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             empty,
    output logic             read_en,
    input  logic [WIDTH-1:0] data_out,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [CNT_W-1:0] rd_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t             state;
    occ_t             state_next;
    logic             inflight;
    logic             pop;
    logic             capture;
    logic [2:0]       held;
    logic [WIDTH-1:0] skid_data;

    // State register: occupancy, in-flight marker, registered valid and handshake count
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            inflight <= 1'b0;
            m_valid  <= 1'b0;
            rd_count <= '0;
        end else begin
            assert (!(state == FULL && capture && !pop))
                else $error("fifo_reader: capture with no free slot");
            state    <= state_next;
            inflight <= read_en;
            m_valid  <= (state_next != EMPTY);
            if (pop) begin
                rd_count <= rd_count + 1'b1;
            end
        end
    end

    // Next-state: capture adds a word, pop removes one, both together cancel
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (capture) state_next = ONE;
            ONE: begin
                if (capture && !pop) begin
                    state_next = FULL;
                end else if (!capture && pop) begin
                    state_next = EMPTY;
                end
            end
            FULL:    if (pop && !capture) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    // Outputs: a read is only issued when a slot is guaranteed when its word returns
    always_comb begin
        pop     = m_valid && m_ready;
        capture = inflight;
        held    = {1'b0, state} + {2'b00, inflight} - {2'b00, pop};
        read_en = !rst && enable && !empty && (held < 3'd2);
    end

    // Output register: the skid word always takes precedence over a fresh capture
    always_ff @(posedge clk) begin
        if (rst) begin
            m_data <= '0;
        end else if (state == FULL && pop) begin
            m_data <= skid_data;
        end else if (capture && (state == EMPTY || pop)) begin
            m_data <= data_out;
        end
    end

    always_ff @(posedge clk) begin
        if (capture && ((state == ONE && !pop) || (state == FULL && pop))) begin
            skid_data <= data_out;
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: a behavioural FIFO feeds the DUT and the
// delivered stream is compared against the written word sequence.
module tb_fifo_reader;

    localparam int WIDTH = 3;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             empty;
    logic             read_en;
    logic [WIDTH-1:0] data_out;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [CNT_W-1:0] rd_count;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fifo_reader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .empty   (empty),
        .read_en (read_en),
        .data_out(data_out),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .rd_count(rd_count)
    );

    // Behavioural FIFO: registered read data, flushed by reset
    logic [WIDTH-1:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= wr_ptr;
            data_out <= WIDTH'($urandom);
        end else if (read_en && !empty) begin
            data_out <= mem[rd_ptr % 1024];
            rd_ptr   <= rd_ptr + 1;
        end else begin
            data_out <= WIDTH'($urandom);
        end
    end

    // Delivered-word log and over-read detector
    logic [WIDTH-1:0] got_q[$];
    int overread = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) got_q.push_back(m_data);
            if (read_en && empty) overread++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] v);
        mem[wr_ptr % 1024] = v;
        wr_ptr++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        m_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b1;
        m_ready = 1'b1;
        push_word(3'd5);
        @(negedge clk);
        n_chk++;
        if (read_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_read_en: got %b want 0", read_en);
        end
        n_chk++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_m_valid: got %b want 0", m_valid);
        end
        n_chk++;
        if (m_data !== '0) begin
            n_fail++;
            $display("FAIL reset_m_data: got %0d want 0", m_data);
        end
        n_chk++;
        if (rd_count !== '0) begin
            n_fail++;
            $display("FAIL reset_rd_count: got %0d want 0", rd_count);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (read_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flush_read_en: got %b want 0", read_en);
        end
        step();
    endtask

    task automatic test_preload();
        logic [WIDTH-1:0] seq [4];
        logic [11:0] re_v;
        logic [11:0] mv_v;
        logic [WIDTH-1:0] md [12];
        int base;
        seq = '{3'd3, 3'd1, 3'd4, 3'd2};
        do_reset();
        m_ready = 1'b1;
        foreach (seq[i]) push_word(seq[i]);
        base = got_q.size();
        enable = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            re_v[c] = read_en;
            mv_v[c] = m_valid;
            md[c]   = m_data;
        end
        n_chk++;
        if (re_v !== 12'b0000_0000_1111) begin
            n_fail++;
            $display("FAIL preload_read_en_pattern: got %b want %b", re_v, 12'b0000_0000_1111);
        end
        n_chk++;
        if (mv_v !== 12'b0000_0011_1100) begin
            n_fail++;
            $display("FAIL preload_m_valid_pattern: got %b want %b", mv_v, 12'b0000_0011_1100);
        end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (md[i+2] !== seq[i]) begin
                n_fail++;
                $display("FAIL preload_m_data[%0d]: got %0d want %0d", i, md[i+2], seq[i]);
            end
        end
        n_chk++;
        if (rd_count !== 8'd4) begin
            n_fail++;
            $display("FAIL preload_rd_count: got %0d want 4", rd_count);
        end
        n_chk++;
        if (got_q.size() - base !== 4) begin
            n_fail++;
            $display("FAIL preload_delivered: got %0d want 4", got_q.size() - base);
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] w [5];
        int rcount = 0;
        int hold_bad = 0;
        int hs = 0;
        int bad = 0;
        int base;
        do_reset();
        foreach (w[i]) begin
            w[i] = WIDTH'($urandom);
            push_word(w[i]);
        end
        enable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (read_en) rcount++;
            if (c >= 2 && !(m_valid === 1'b1 && m_data === w[0])) hold_bad++;
        end
        n_chk++;
        if (rcount !== 2) begin
            n_fail++;
            $display("FAIL bp_read_pulses: got %0d want 2", rcount);
        end
        n_chk++;
        if (hold_bad !== 0) begin
            n_fail++;
            $display("FAIL bp_hold_word0: got %0d unstable cycles want 0", hold_bad);
        end
        step();
        base = got_q.size();
        m_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (m_valid) hs++;
        end
        for (int c = 0; c < 6; c++) @(negedge clk);
        n_chk++;
        if (hs !== 5) begin
            n_fail++;
            $display("FAIL bp_no_gaps: got %0d handshakes in 5 cycles want 5", hs);
        end
        n_chk++;
        if (got_q.size() - base !== 5) begin
            n_fail++;
            $display("FAIL bp_count: got %0d want 5", got_q.size() - base);
        end else begin
            for (int i = 0; i < 5; i++) if (got_q[base+i] !== w[i]) bad++;
            n_chk++;
            if (bad !== 0) begin
                n_fail++;
                $display("FAIL bp_order: got %0d misordered words want 0", bad);
            end
        end
        n_chk++;
        if (rd_count !== 8'd5) begin
            n_fail++;
            $display("FAIL bp_rd_count: got %0d want 5", rd_count);
        end
        step();
    endtask

    task automatic test_empty_idle();
        logic [WIDTH-1:0] v;
        int re_n = 0;
        int mv_n = 0;
        int base;
        do_reset();
        enable = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (read_en) re_n++;
            if (m_valid) mv_n++;
        end
        n_chk++;
        if (re_n !== 0 || mv_n !== 0) begin
            n_fail++;
            $display("FAIL idle_activity: got read_en=%0d m_valid=%0d cycles want 0 0", re_n, mv_n);
        end
        step();
        base = got_q.size();
        v = WIDTH'($urandom);
        push_word(v);
        re_n = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (read_en) re_n++;
        end
        n_chk++;
        if (re_n !== 1) begin
            n_fail++;
            $display("FAIL idle_single_read: got %0d want 1", re_n);
        end
        n_chk++;
        if (got_q.size() - base !== 1 || got_q[got_q.size()-1] !== v) begin
            n_fail++;
            $display("FAIL idle_single_word: got %0d words last %0d want 1 word %0d",
                     got_q.size() - base, got_q[got_q.size()-1], v);
        end
        step();
    endtask

    task automatic test_enable_gap();
        logic [WIDTH-1:0] w [30];
        int re_n = 0;
        int hs = 0;
        int bad = 0;
        int base;
        do_reset();
        m_ready = 1'b1;
        foreach (w[i]) begin
            w[i] = WIDTH'($urandom);
            push_word(w[i]);
        end
        base = got_q.size();
        enable = 1'b1;
        for (int c = 0; c < 6; c++) @(negedge clk);
        step();
        enable = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (read_en) re_n++;
            if (m_valid && m_ready) hs++;
        end
        step();
        enable = 1'b1;
        n_chk++;
        if (re_n !== 0) begin
            n_fail++;
            $display("FAIL gap_read_en: got %0d pulses want 0", re_n);
        end
        n_chk++;
        if (hs !== 2) begin
            n_fail++;
            $display("FAIL gap_drain: got %0d words drained want 2", hs);
        end
        for (int c = 0; c < 80 && got_q.size() - base < 30; c++) @(negedge clk);
        n_chk++;
        if (got_q.size() - base !== 30) begin
            n_fail++;
            $display("FAIL gap_count: got %0d want 30", got_q.size() - base);
        end else begin
            for (int i = 0; i < 30; i++) if (got_q[base+i] !== w[i]) bad++;
            n_chk++;
            if (bad !== 0) begin
                n_fail++;
                $display("FAIL gap_order: got %0d misordered words want 0", bad);
            end
        end
        step();
    endtask

    task automatic test_mid_reset();
        logic [WIDTH-1:0] w [3];
        int bad = 0;
        int base;
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) push_word(WIDTH'($urandom));
        enable = 1'b1;
        for (int c = 0; c < 4; c++) @(negedge clk);
        step();
        rst = 1'b1;
        m_ready = 1'b0;
        base = got_q.size();
        step();
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (m_valid !== 1'b0 || rd_count !== '0 || read_en !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_state: got m_valid=%b rd_count=%0d read_en=%b want 0 0 0",
                     m_valid, rd_count, read_en);
        end
        step();
        m_ready = 1'b1;
        foreach (w[i]) begin
            w[i] = WIDTH'($urandom);
            push_word(w[i]);
        end
        for (int c = 0; c < 12; c++) @(negedge clk);
        n_chk++;
        if (got_q.size() - base !== 3) begin
            n_fail++;
            $display("FAIL midrst_count: got %0d want 3", got_q.size() - base);
        end else begin
            for (int i = 0; i < 3; i++) if (got_q[base+i] !== w[i]) bad++;
            n_chk++;
            if (bad !== 0) begin
                n_fail++;
                $display("FAIL midrst_order: got %0d wrong words want 0", bad);
            end
        end
        step();
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] w [300];
        logic [WIDTH-1:0] prev_d = '0;
        logic [CNT_W-1:0] prev_cnt = '0;
        logic prev_hold = 1'b0;
        logic wrapped = 1'b0;
        int hold_bad = 0;
        int bad = 0;
        int base;
        do_reset();
        base = got_q.size();
        foreach (w[i]) begin
            w[i] = WIDTH'($urandom);
            push_word(w[i]);
        end
        for (int c = 0; c < 3000 && got_q.size() - base < 300; c++) begin
            m_ready = 1'($urandom_range(0, 1));
            enable  = ($urandom_range(0, 7) != 0);
            @(negedge clk);
            if (prev_hold && !(m_valid === 1'b1 && m_data === prev_d)) hold_bad++;
            prev_hold = m_valid && !m_ready;
            prev_d    = m_data;
            if (prev_cnt == 8'd255 && rd_count == 8'd0) wrapped = 1'b1;
            prev_cnt  = rd_count;
            step();
        end
        n_chk++;
        if (got_q.size() - base !== 300) begin
            n_fail++;
            $display("FAIL rand_count: got %0d want 300", got_q.size() - base);
        end else begin
            for (int i = 0; i < 300; i++) if (got_q[base+i] !== w[i]) bad++;
            n_chk++;
            if (bad !== 0) begin
                n_fail++;
                $display("FAIL rand_order: got %0d misordered words want 0", bad);
            end
        end
        n_chk++;
        if (hold_bad !== 0) begin
            n_fail++;
            $display("FAIL rand_hold_stable: got %0d violations want 0", hold_bad);
        end
        n_chk++;
        if (wrapped !== 1'b1) begin
            n_fail++;
            $display("FAIL rand_wrap: got %b want 1", wrapped);
        end
        n_chk++;
        if (rd_count !== 8'd44) begin
            n_fail++;
            $display("FAIL rand_rd_count: got %0d want 44", rd_count);
        end
        n_chk++;
        if (overread !== 0) begin
            n_fail++;
            $display("FAIL over_read: got %0d reads while empty want 0", overread);
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_backpressure();
        test_empty_idle();
        test_enable_gap();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
